store_write_queue: RTL and testbench

//  Posted-store queue between MEM stage and data-memory/bridge write port.
//  - Accepts SW/SH/SB stores, generates byte enables and lane-placed write data, buffers up to DEPTH entries.
//  - Drains entries in order to the bus with a req/ack handshake.
//  - Flags loads that hit a pending word so the hazard unit can stall them.

---
 rtl/store_q_pkg.sv | 19 +
 rtl/store_lane_align.sv | 47 ++++
 rtl/store_write_queue.sv | 132 +++++++++++++
 tb/tb_store_write_queue.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/store_q_pkg.sv
// Shared types and constants for the posted-store write queue.
// Store type codes, drain FSM encoding and byte-enable patterns.
package store_q_pkg;

  localparam logic [1:0] ST_SW  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SB  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_LO   = 4'b0011;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } drain_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Converts a raw store (type, low address bits, source value) into
// byte enables and lane-placed write data, and flags misalignment.
module store_lane_align
  import store_q_pkg::*;
(
  input  logic [1:0]  st_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  byteen,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    byteen   = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    case (st_type)
      ST_SW: begin
        byteen   = BE_WORD;
        wdata    = st_data;
        misalign = (addr_lo != 2'b00);
      end
      ST_SH: begin
        misalign = addr_lo[0];
        if (addr_lo[1]) begin
          byteen = BE_HI;
          wdata  = {st_data[15:0], 16'h0};
        end else begin
          byteen = BE_LO;
          wdata  = {16'h0, st_data[15:0]};
        end
      end
      ST_SB: begin
        byteen = 4'b0001 << addr_lo;
        wdata  = {24'h0, st_data[7:0]} << {addr_lo, 3'b000};
      end
      default: begin
        // Reserved type produces no write and no error.
        byteen   = 4'b0000;
        wdata    = 32'h0;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_write_queue.sv
// Posted-store queue between MEM stage and the data write port: buffers
// aligned stores, drains them in order over req/ack, and flags load hazards.
module store_write_queue
  import store_q_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_type,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hazard,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_byteen,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  output logic          q_empty,
  output drain_state_e  dbg_state,
  output logic [CW-1:0] dbg_count
);

  // Handshakes: a store transfers on a rising edge where st_valid & st_ready
  // (producer holds the store while st_ready=0); a bus write transfers on an
  // edge where bus_req & bus_ack, and bus_* stay stable until that edge.

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  drain_state_e  state, state_next;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, count_next;

  logic [AW-3:0] q_addr [DEPTH];
  logic [3:0]    q_be   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [DEPTH-1:0] q_vld;

  logic [3:0]  al_byteen;
  logic [31:0] al_wdata;
  logic        al_misalign;
  logic        push, pop, hit;

  store_lane_align u_align (
    .st_type  (st_type),
    .addr_lo  (st_addr[1:0]),
    .st_data  (st_data),
    .byteen   (al_byteen),
    .wdata    (al_wdata),
    .misalign (al_misalign)
  );

  assign st_ready = (count < FULL);
  assign push     = st_valid & st_ready & ~al_misalign & (st_type != ST_RSV);
  assign pop      = (state == S_REQ) & bus_ack;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (count != '0) state_next = S_REQ;
      S_REQ:  if (pop && (count_next == '0)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      q_vld       <= '0;
      st_misalign <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      st_misalign <= st_valid & al_misalign;
      if (pop) begin
        head        <= head + 1'b1;
        q_vld[head] <= 1'b0;
      end
      // Push never lands on the head slot while it is still valid: no push when full.
      if (push) begin
        tail        <= tail + 1'b1;
        q_vld[tail] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= st_addr[AW-1:2];
      q_be[tail]   <= al_byteen;
      q_data[tail] <= al_wdata;
    end
  end

  // Word-granular match against every pending entry, including the in-flight head.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_addr[i] == ld_addr[AW-1:2])) hit = 1'b1;
    end
  end

  assign ld_hazard  = ld_valid & hit;
  assign bus_req    = (state == S_REQ);
  assign bus_addr   = bus_req ? {q_addr[head], 2'b00} : '0;
  assign bus_byteen = bus_req ? q_be[head] : 4'b0000;
  assign bus_wdata  = bus_req ? q_data[head] : 32'h0;
  assign q_empty    = (count == '0) & (state == S_IDLE);
  assign dbg_state  = state;
  assign dbg_count  = count;

endmodule

// File: tb/tb_store_write_queue.sv
// Directed bench for store_write_queue: expected bus writes are queued at
// issue time and compared by a monitor whenever a bus transfer occurs.
module tb_store_write_queue;
  import store_q_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          st_valid;
  logic [1:0]    st_type;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_ready;
  logic          st_misalign;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_hazard;
  logic          bus_req;
  logic [AW-1:0] bus_addr;
  logic [3:0]    bus_byteen;
  logic [31:0]   bus_wdata;
  logic          bus_ack;
  logic          q_empty;
  drain_state_e  dbg_state;
  logic [CW-1:0] dbg_count;

  store_write_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_type     (st_type),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_ready    (st_ready),
    .st_misalign (st_misalign),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .bus_req     (bus_req),
    .bus_addr    (bus_addr),
    .bus_byteen  (bus_byteen),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .q_empty     (q_empty),
    .dbg_state   (dbg_state),
    .dbg_count   (dbg_count)
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_exp;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] ent(input logic [31:0] a, input logic [3:0] be,
                                      input logic [31:0] d);
    return {a, be, d};
  endfunction

  // Monitor: a transfer happens at the next rising edge when req & ack are both high.
  always @(negedge clk) begin
    if (!reset && bus_req && bus_ack) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL bus_unexpected: got write addr %0h be %b data %0h, none expected",
                 bus_addr, bus_byteen, bus_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bus_xfer", {bus_addr, bus_byteen, bus_wdata}, mon_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_type  = t;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    bus_ack = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && q_empty) break;
      tick();
    end
    check("drain_exp_left", 68'(exp_q.size()), 68'd0);
    check("drain_q_empty", q_empty, 1'b1);
    bus_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_type  = ST_SW;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 1'b0;
    ld_addr  = '0;
    bus_ack  = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_q_empty", q_empty, 1'b1);
    check("rst_misalign", st_misalign, 1'b0);
    check("rst_bus_bundle", {bus_addr, bus_byteen, bus_wdata}, 68'h0);
    check("rst_count", dbg_count, 0);
    check("rst_state", dbg_state, S_IDLE);

    // 1: SB with ack held high; request appears two edges after the store
    bus_ack = 1'b1;
    exp_q.push_back(ent(32'h0000_1000, 4'b1000, 32'hAB00_0000));
    store(ST_SB, 32'h0000_1003, 32'h0000_00AB);
    check("t1_req_after_n", bus_req, 1'b0);
    tick();
    check("t1_req_after_n1", bus_req, 1'b1);
    check("t1_bus_addr", bus_addr, 32'h0000_1000);
    tick();
    check("t1_req_dropped", bus_req, 1'b0);
    check("t1_q_empty", q_empty, 1'b1);

    // 2: fill with four words, no ack
    bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ent(32'(i * 4), BE_WORD, 32'hC0DE_0000 + 32'(i)));
      store(ST_SW, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    end
    check("t2_full_ready", st_ready, 1'b0);
    check("t2_full_count", dbg_count, 4);
    store(ST_SW, 32'h0000_0010, 32'hDEAD_BEEF);
    check("t2_reject_count", dbg_count, 4);
    check("t2_head_req", bus_req, 1'b1);
    check("t2_head_addr", bus_addr, 32'h0);

    // 3: full queue, ack plus a held SH; SH enters once a slot frees
    st_valid = 1'b1;
    st_type  = ST_SH;
    st_addr  = 32'h0000_0012;
    st_data  = 32'h0000_1234;
    bus_ack  = 1'b1;
    tick();
    check("t3_pop_only_count", dbg_count, 3);
    check("t3_ready_again", st_ready, 1'b1);
    exp_q.push_back(ent(32'h0000_0010, BE_HI, 32'h1234_0000));
    tick();
    check("t3_push_pop_count", dbg_count, 3);
    st_valid = 1'b0;
    drain(12);

    // 4: misaligned stores and the reserved type
    store(ST_SW, 32'h0000_2002, 32'h1111_1111);
    check("t4_sw_misalign", st_misalign, 1'b1);
    check("t4_sw_count", dbg_count, 0);
    tick();
    check("t4_sw_pulse_end", st_misalign, 1'b0);
    store(ST_SH, 32'h0000_2001, 32'h2222_2222);
    check("t4_sh_misalign", st_misalign, 1'b1);
    check("t4_sh_count", dbg_count, 0);
    tick();
    check("t4_sh_pulse_end", st_misalign, 1'b0);
    store(ST_RSV, 32'h0000_2000, 32'h3333_3333);
    check("t4_rsv_misalign", st_misalign, 1'b0);
    check("t4_rsv_count", dbg_count, 0);
    check("t4_rsv_q_empty", q_empty, 1'b1);

    // 5: load hazard against pending entries
    exp_q.push_back(ent(32'h0000_3000, 4'b0010, 32'h0000_CD00));
    store(ST_SB, 32'h0000_3001, 32'hFFFF_FFCD);
    exp_q.push_back(ent(32'h0000_3008, BE_LO, 32'h0000_5678));
    store(ST_SH, 32'h0000_3008, 32'hBEEF_5678);
    exp_q.push_back(ent(32'h0000_300C, BE_HI, 32'hABCD_0000));
    store(ST_SH, 32'h0000_300E, 32'h0000_ABCD);
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_3003;
    #1 check("t5_hit_same_word", ld_hazard, 1'b1);
    ld_addr = 32'h0000_3004;
    #1 check("t5_miss_next_word", ld_hazard, 1'b0);
    ld_addr = 32'h0000_300C;
    #1 check("t5_hit_third", ld_hazard, 1'b1);
    ld_valid = 1'b0;
    ld_addr  = 32'h0000_3003;
    #1 check("t5_no_ld_valid", ld_hazard, 1'b0);
    tick();
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_3010;
    st_valid = 1'b1;
    st_type  = ST_SW;
    st_addr  = 32'h0000_3010;
    st_data  = 32'h5555_AAAA;
    exp_q.push_back(ent(32'h0000_3010, BE_WORD, 32'h5555_AAAA));
    #1 check("t5_same_cycle_store", ld_hazard, 1'b0);
    tick();
    st_valid = 1'b0;
    check("t5_after_enqueue", ld_hazard, 1'b1);
    ld_valid = 1'b0;
    drain(16);

    // 6: reset while a request is outstanding
    for (int i = 0; i < 3; i++) store(ST_SW, 32'h40 + 32'(i * 4), 32'h0BAD_0000 + 32'(i));
    tick();
    check("t6_req_before", bus_req, 1'b1);
    check("t6_count_before", dbg_count, 3);
    reset   = 1'b1;
    bus_ack = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_req_dropped", bus_req, 1'b0);
    check("t6_count_zero", dbg_count, 0);
    check("t6_ready", st_ready, 1'b1);
    check("t6_q_empty", q_empty, 1'b1);
    tick();
    check("t6_stale_ack_req", bus_req, 1'b0);
    check("t6_stale_ack_empty", q_empty, 1'b1);
    bus_ack = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
